stack_op_sequencer: RTL and testbench

- Sits between the operand-stack users (bytecode execute stage) and the single-port `stack` block.
- Accepts one compound stack command at a time: PUSH, POP, POP2, DUP or SWAP.
- Breaks each command into single push/pop micro-operations on the stack's trigger/push/done handshake.
- Returns popped operands, tracks stack depth and reports completion with a one-cycle pulse.

---
 rtl/stack_op_sequencer_if.sv | 35 +++
 rtl/stack_op_sequencer.sv | 147 ++++++++++++++
 tb/tb_stack_op_sequencer.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_op_sequencer_if.sv
// Command/result and stack micro-op signals for stack_op_sequencer.
// slave = sequencer side, master = execute stage plus attached stack.
interface stack_op_sequencer_if #(
  parameter int STACKDATA = 32,
  parameter int STACKSIZE = 65536
);
  localparam int DW = $clog2(STACKSIZE) + 1;

  logic                 cmd_valid;
  logic [2:0]           cmd;
  logic                 cmd_ready;
  logic [STACKDATA-1:0] push_value;
  logic [STACKDATA-1:0] result_a;
  logic [STACKDATA-1:0] result_b;
  logic                 done;
  logic                 error;
  logic [DW-1:0]        depth;
  logic                 stack_trigger;
  logic                 stack_push;
  logic [STACKDATA-1:0] stack_write_value;
  logic [STACKDATA-1:0] stack_read_value;
  logic                 stack_done;

  modport slave (
    input  cmd_valid, cmd, push_value, stack_read_value, stack_done,
    output cmd_ready, result_a, result_b, done, error, depth,
           stack_trigger, stack_push, stack_write_value
  );

  modport master (
    output cmd_valid, cmd, push_value, stack_read_value, stack_done,
    input  cmd_ready, result_a, result_b, done, error, depth,
           stack_trigger, stack_push, stack_write_value
  );
endinterface

// File: rtl/stack_op_sequencer.sv
// Splits PUSH/POP/POP2/DUP/SWAP into single push/pop micro-ops on the stack handshake.
// Optional STACK_DEPTH_CHECK_EN rejects commands that would under/overflow the stack.
module stack_op_sequencer #(
  parameter int STACKDATA = 32,
  parameter int STACKSIZE = 65536
) (
  input  logic                 clk,
  input  logic                 rst,
  stack_op_sequencer_if.slave  bus
);
  localparam int DW = $clog2(STACKSIZE) + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  localparam logic [2:0] C_PUSH = 3'd1;
  localparam logic [2:0] C_POP  = 3'd2;
  localparam logic [2:0] C_POP2 = 3'd3;
  localparam logic [2:0] C_DUP  = 3'd4;
  localparam logic [2:0] C_SWAP = 3'd5;

  localparam logic [1:0] D_A = 2'd0;
  localparam logic [1:0] D_B = 2'd1;
  localparam logic [1:0] D_T = 2'd2;

  logic [1:0]           r_state;
  logic [2:0]           r_cmd;
  logic [1:0]           r_idx;
  logic [STACKDATA-1:0] r_value;
  logic [STACKDATA-1:0] r_tmp;
  logic [STACKDATA-1:0] r_a;
  logic [STACKDATA-1:0] r_b;
  logic [DW-1:0]        r_depth;
  logic                 r_err;

  logic                 w_push;
  logic                 w_last;
  logic [1:0]           w_dst;
  logic [STACKDATA-1:0] w_wval;
  logic                 w_accept;
  logic                 w_known;
  logic                 w_reject;

  // Micro-op currently selected by (r_cmd, r_idx)
  always_comb begin
    w_push = 1'b0;
    w_last = 1'b1;
    w_dst  = D_A;
    w_wval = r_value;
    case (r_cmd)
      C_PUSH: w_push = 1'b1;
      C_POP:  w_dst  = D_A;
      C_POP2: begin
        w_dst  = (r_idx == 2'd0) ? D_A : D_B;
        w_last = (r_idx == 2'd1);
      end
      C_DUP: begin
        w_dst  = D_T;
        w_push = (r_idx != 2'd0);
        w_wval = r_tmp;
        w_last = (r_idx == 2'd2);
      end
      C_SWAP: begin
        w_dst  = (r_idx == 2'd0) ? D_A : D_B;
        w_push = (r_idx >= 2'd2);
        w_wval = (r_idx == 2'd2) ? r_a : r_b;
        w_last = (r_idx == 2'd3);
      end
      default: ;
    endcase
  end

  assign w_accept = bus.cmd_valid && (r_state == S_IDLE);
  assign w_known  = (bus.cmd >= C_PUSH) && (bus.cmd <= C_SWAP);

`ifdef STACK_DEPTH_CHECK_EN
  always_comb begin
    w_reject = 1'b0;
    case (bus.cmd)
      C_PUSH:         w_reject = (r_depth == DW'(STACKSIZE));
      C_POP:          w_reject = (r_depth == '0);
      C_DUP:          w_reject = (r_depth == '0) || (r_depth == DW'(STACKSIZE));
      C_POP2, C_SWAP: w_reject = (r_depth < DW'(2));
      default:        w_reject = 1'b0;
    endcase
  end
`else
  assign w_reject = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cmd   <= '0;
      r_idx   <= '0;
      r_value <= '0;
      r_tmp   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_depth <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_cmd   <= bus.cmd;
          r_value <= bus.push_value;
          r_idx   <= '0;
          r_err   <= w_reject;
          r_state <= (w_known && !w_reject) ? S_ISSUE : S_FINISH;
        end
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: if (bus.stack_done) begin
          if (!w_push) begin
            case (w_dst)
              D_A:     r_a   <= bus.stack_read_value;
              D_B:     r_b   <= bus.stack_read_value;
              default: r_tmp <= bus.stack_read_value;
            endcase
          end
          r_depth <= w_push ? r_depth + DW'(1) : r_depth - DW'(1);
          if (w_last) begin
            r_state <= S_FINISH;
          end else begin
            r_idx   <= r_idx + 2'd1;
            r_state <= S_ISSUE;
          end
        end
        default: begin
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready         = (r_state == S_IDLE);
  assign bus.stack_trigger     = (r_state == S_ISSUE);
  assign bus.stack_push        = (r_state == S_ISSUE) && w_push;
  assign bus.stack_write_value = (r_state == S_ISSUE) ? w_wval : '0;
  assign bus.done              = (r_state == S_FINISH);
  assign bus.error             = (r_state == S_FINISH) && r_err;
  assign bus.result_a          = r_a;
  assign bus.result_b          = r_b;
  assign bus.depth             = r_depth;
endmodule

// File: tb/tb_stack_op_sequencer.sv
// Randomized bench for stack_op_sequencer: a queue-based command model and a
// behavioural stack responder with random latency.
module tb_stack_op_sequencer;
  localparam int STACKDATA = 32;
  localparam int STACKSIZE = 65536;

  localparam logic [2:0] C_NOP  = 3'd0;
  localparam logic [2:0] C_PUSH = 3'd1;
  localparam logic [2:0] C_POP  = 3'd2;
  localparam logic [2:0] C_POP2 = 3'd3;
  localparam logic [2:0] C_DUP  = 3'd4;
  localparam logic [2:0] C_SWAP = 3'd5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stack_op_sequencer_if #(.STACKDATA(STACKDATA), .STACKSIZE(STACKSIZE)) ifc ();

  stack_op_sequencer #(.STACKDATA(STACKDATA), .STACKSIZE(STACKSIZE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural stack attached to the DUT
  logic [STACKDATA-1:0] stk[$];
  int lat_cfg = 2;

  initial begin
    logic [STACKDATA-1:0] rv;
    logic                 was_push;
    ifc.stack_done       = 1'b0;
    ifc.stack_read_value = '0;
    forever begin
      @(negedge clk);
      ifc.stack_done = 1'b0;
      if (ifc.stack_trigger) begin
        was_push = ifc.stack_push;
        rv = '0;
        if (was_push) stk.push_back(ifc.stack_write_value);
        else if (stk.size() > 0) rv = stk.pop_back();
        else rv = 32'hDEAD_BEEF;
        repeat (lat_cfg) @(negedge clk);
        ifc.stack_read_value = was_push ? $urandom : rv;
        ifc.stack_done = 1'b1;
      end
    end
  end

  // Observed activity per command
  int                   mon_trig, mon_pops, mon_done, mon_err;
  logic [STACKDATA-1:0] mon_push[$];

  initial begin
    forever begin
      @(negedge clk);
      if (ifc.stack_trigger) begin
        mon_trig++;
        if (ifc.stack_push) mon_push.push_back(ifc.stack_write_value);
        else mon_pops++;
      end
      if (ifc.done)  mon_done++;
      if (ifc.error) mon_err++;
    end
  end

  // Reference model: top of stack is the back of the queue
  logic [STACKDATA-1:0] mq[$];
  logic [STACKDATA-1:0] mdl_a = '0;
  logic [STACKDATA-1:0] mdl_b = '0;

  task automatic run_cmd(input logic [2:0] c, input logic [STACKDATA-1:0] v);
    logic                 e_rej;
    int                   e_pops;
    logic [STACKDATA-1:0] e_push[$];
    logic [STACKDATA-1:0] t, u;
    int                   sz, n;
    logic                 got;
    sz = mq.size();
    e_rej = 1'b0;
    e_pops = 0;
`ifdef STACK_DEPTH_CHECK_EN
    case (c)
      C_PUSH:         e_rej = (sz == STACKSIZE);
      C_POP:          e_rej = (sz == 0);
      C_DUP:          e_rej = (sz == 0) || (sz == STACKSIZE);
      C_POP2, C_SWAP: e_rej = (sz < 2);
      default:        e_rej = 1'b0;
    endcase
`endif
    if (!e_rej) begin
      case (c)
        C_PUSH: begin mq.push_back(v); e_push.push_back(v); end
        C_POP:  begin mdl_a = mq.pop_back(); e_pops = 1; end
        C_POP2: begin mdl_a = mq.pop_back(); mdl_b = mq.pop_back(); e_pops = 2; end
        C_DUP: begin
          t = mq.pop_back();
          mq.push_back(t); mq.push_back(t);
          e_push.push_back(t); e_push.push_back(t);
          e_pops = 1;
        end
        C_SWAP: begin
          t = mq.pop_back(); u = mq.pop_back();
          mdl_a = t; mdl_b = u;
          mq.push_back(t); mq.push_back(u);
          e_push.push_back(t); e_push.push_back(u);
          e_pops = 2;
        end
        default: ;
      endcase
    end

    mon_trig = 0; mon_pops = 0; mon_done = 0; mon_err = 0;
    mon_push.delete();
    lat_cfg = $urandom_range(1, 3);

    n = 0;
    while (!ifc.cmd_ready && n < 50) begin @(negedge clk); n++; end
    chk("ready_before_cmd", ifc.cmd_ready, 1'b1);

    ifc.cmd        = c;
    ifc.push_value = v;
    ifc.cmd_valid  = 1'b1;
    n = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        ifc.cmd_valid  = 1'b0;
        ifc.push_value = $urandom;
        ifc.cmd        = 3'($urandom);
      end
      if (ifc.done) got = 1'b1;
    end
    chk($sformatf("done_seen cmd%0d", c), got, 1'b1);
    if (e_rej) chk("reject_latency", n, 1);
    @(negedge clk);

    chk($sformatf("done_count cmd%0d", c), mon_done, 1);
    chk($sformatf("error_count cmd%0d", c), mon_err, e_rej);
    chk($sformatf("trig_count cmd%0d", c), mon_trig, e_pops + e_push.size());
    chk($sformatf("pop_count cmd%0d", c), mon_pops, e_pops);
    chk($sformatf("push_count cmd%0d", c), mon_push.size(), e_push.size());
    for (int i = 0; i < e_push.size(); i++)
      if (i < mon_push.size()) chk($sformatf("push_val%0d cmd%0d", i, c), mon_push[i], e_push[i]);
    chk($sformatf("depth cmd%0d", c), ifc.depth, mq.size());
    chk($sformatf("result_a cmd%0d", c), ifc.result_a, mdl_a);
    chk($sformatf("result_b cmd%0d", c), ifc.result_b, mdl_b);
  endtask

  initial begin
    logic [2:0] c;
    int         n;
    ifc.cmd_valid  = 1'b0;
    ifc.cmd        = C_NOP;
    ifc.push_value = '0;

    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", ifc.cmd_ready, 1'b1);
    chk("rst_outputs", {ifc.done, ifc.error, ifc.stack_trigger, ifc.stack_push}, 4'b0);
    chk("rst_depth", ifc.depth, 0);
    chk("rst_results", {ifc.result_a, ifc.result_b, ifc.stack_write_value}, 96'b0);
    rst = 1'b0;
    @(negedge clk);

`ifdef STACK_DEPTH_CHECK_EN
    run_cmd(C_POP, '0);
    run_cmd(C_SWAP, '0);
    run_cmd(C_POP2, '0);
`endif

    run_cmd(C_PUSH, 32'h0000_00AA);
    run_cmd(C_PUSH, 32'h0000_00BB);
    run_cmd(C_POP2, '0);
    run_cmd(C_PUSH, 32'd1);
    run_cmd(C_PUSH, 32'd2);
    run_cmd(C_SWAP, '0);
    run_cmd(C_POP2, '0);
    run_cmd(C_PUSH, 32'h0000_1234);
    run_cmd(C_DUP, '0);
    run_cmd(C_POP2, '0);
    run_cmd(C_NOP, 32'h5555_5555);
    run_cmd(3'd7, 32'h6666_6666);

    for (int k = 0; k < 60; k++) begin
      c = 3'($urandom_range(0, 7));
`ifndef STACK_DEPTH_CHECK_EN
      if ((c == C_POP || c == C_DUP) && mq.size() < 1) c = C_PUSH;
      if ((c == C_POP2 || c == C_SWAP) && mq.size() < 2) c = C_PUSH;
`endif
      if (c == C_PUSH && mq.size() > 20) c = C_POP;
      run_cmd(c, $urandom);
    end

    // Reset in the middle of a DUP
    if (mq.size() < 1) run_cmd(C_PUSH, 32'hCAFE_0001);
    mon_done = 0;
    lat_cfg = 3;
    ifc.cmd = C_DUP;
    ifc.cmd_valid = 1'b1;
    @(negedge clk);
    ifc.cmd_valid = 1'b0;
    n = 0;
    while (!ifc.stack_trigger && n < 20) begin @(negedge clk); n++; end
    chk("dup_trigger_seen", ifc.stack_trigger, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_cmd_ready", ifc.cmd_ready, 1'b1);
    chk("midrst_outputs", {ifc.done, ifc.error, ifc.stack_trigger, ifc.stack_push}, 4'b0);
    chk("midrst_depth", ifc.depth, 0);
    chk("midrst_results", {ifc.result_a, ifc.result_b}, 64'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst_no_done", mon_done, 0);
    chk("midrst_depth_after", ifc.depth, 0);
    chk("midrst_ready_after", ifc.cmd_ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
    $fatal(1);
  end
endmodule
